// File: rtl/depermutator.sv
// rtl/depermutator.sv - receive-side inverse of the scan-bus permutator with 2-entry valid/ready buffer
//
// Purpose:
//   Restores a permuted scan-bus word from the word and the control code that
//   produced it. The inverse is computed when the word is pushed and is stored
//   together with a lossy flag. A 2-entry buffer (head + skid register) gives
//   full throughput. in_ready depends on registered state only.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready     input handshake
//   in_data, in_cntrl     permuted word and its control code
//   out_valid/out_ready   output handshake
//   out_data, out_lossy   restored word and its "not exact" flag
//   cnt_clr               synchronous clear of loss_cnt
//   loss_cnt              saturating count of lossy words delivered
//
// Optional feature:
//   DEPERM_LOSSCNT_EN     when defined, loss_cnt counts lossy pops.
//                         When undefined, loss_cnt is 0 and cnt_clr is ignored.

module depermutator #(
    parameter int scBusSize = 37,
    parameter int cntrlSize = 4,
    parameter int cntWidth  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [scBusSize-1:0] in_data,
    input  logic [cntrlSize-1:0] in_cntrl,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [scBusSize-1:0] out_data,
    output logic                 out_lossy,
    input  logic                 cnt_clr,
    output logic [cntWidth-1:0]  loss_cnt
);

    // The bit map below is hard-wired for a 37-bit bus and a 4-bit code.
    if (scBusSize != 37) begin : g_bad_bus_size
        $error("depermutator: scBusSize must be 37");
    end
    if (cntrlSize != 4) begin : g_bad_cntrl_size
        $error("depermutator: cntrlSize must be 4");
    end

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [scBusSize-1:0] head_data, skid_data;
    logic                 head_lossy, skid_lossy;

    logic [scBusSize-1:0] inv_data;
    logic                 inv_lossy;

    logic push, pop;
    logic load_head_in, load_head_skid, load_skid;

    // Inverse permutation of the incoming word.
    always_comb begin
        inv_data  = '0;
        inv_lossy = 1'b0;
        case (in_cntrl)
            4'd0:  inv_data = ~in_data;
            4'd3,
            4'd7,
            4'd8,
            4'd11: inv_data = in_data;
            // swap of the two end bits
            4'd14: inv_data = {in_data[0], in_data[35:1], in_data[36]};
            // three-field reorder, equivalent to a rotate left by 16
            4'd5:  inv_data = {in_data[20:4], in_data[3:0], in_data[36:21]};
            4'd1: begin
                inv_data  = in_data >> 1;
                inv_lossy = 1'b1;
            end
            4'd2: begin
                inv_data  = in_data << 1;
                inv_lossy = 1'b1;
            end
            4'd12: begin
                inv_data  = in_data >> 2;
                inv_lossy = 1'b1;
            end
            4'd13: begin
                inv_data  = in_data << 2;
                inv_lossy = 1'b1;
            end
            4'd6: begin
                inv_data  = in_data << 6;
                inv_lossy = 1'b1;
            end
            4'd15: begin
                inv_data  = in_data >> 5;
                inv_lossy = 1'b1;
            end
            4'd4: begin
                inv_data[4] = in_data[0];
                inv_lossy   = 1'b1;
            end
            default: begin
                // codes 9 and 10 discard the whole word
                inv_data  = '0;
                inv_lossy = 1'b1;
            end
        endcase
    end

    // Handshake outputs come straight from the state register, so there is
    // no combinational path from out_ready to in_ready.
    assign in_ready  = (state_q != S_FULL);
    assign out_valid = (state_q != S_EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // The head register is the output; the skid register holds the second word.
    // The head is only rewritten when a new word is presented, so it keeps
    // its last value while the buffer is empty.
    always_comb begin
        state_d        = state_q;
        load_head_in   = 1'b0;
        load_head_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_q)
            S_EMPTY: begin
                if (push) begin
                    load_head_in = 1'b1;
                    state_d      = S_ONE;
                end
            end
            S_ONE: begin
                if (push && pop) begin
                    load_head_in = 1'b1;
                end else if (push) begin
                    load_skid = 1'b1;
                    state_d   = S_FULL;
                end else if (pop) begin
                    state_d = S_EMPTY;
                end
            end
            S_FULL: begin
                if (pop) begin
                    load_head_skid = 1'b1;
                    state_d        = S_ONE;
                end
            end
            default: begin
                state_d = S_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_data  <= '0;
            head_lossy <= 1'b0;
        end else if (load_head_in) begin
            head_data  <= inv_data;
            head_lossy <= inv_lossy;
        end else if (load_head_skid) begin
            head_data  <= skid_data;
            head_lossy <= skid_lossy;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_data  <= '0;
            skid_lossy <= 1'b0;
        end else if (load_skid) begin
            skid_data  <= inv_data;
            skid_lossy <= inv_lossy;
        end
    end

    assign out_data  = head_data;
    assign out_lossy = head_lossy;

`ifdef DEPERM_LOSSCNT_EN
    logic [cntWidth-1:0] cnt_q;

    // Clear wins over a same-cycle increment; the count sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (cnt_clr) begin
            cnt_q <= '0;
        end else if (pop && head_lossy && (cnt_q != {cntWidth{1'b1}})) begin
            cnt_q <= cnt_q + {{(cntWidth-1){1'b0}}, 1'b1};
        end
    end

    assign loss_cnt = cnt_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign loss_cnt       = '0;
`endif

endmodule

// File: tb/tb_depermutator.sv
// tb/tb_depermutator.sv - randomized self-checking bench for depermutator

module tb_depermutator;

    localparam int W  = 37;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [3:0]    in_cntrl;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          out_lossy;
    logic          cnt_clr;
    logic [CW-1:0] loss_cnt;

    int checks = 0;
    int errors = 0;

    depermutator #(.scBusSize(W), .cntrlSize(4), .cntWidth(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_cntrl  (in_cntrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_lossy (out_lossy),
        .cnt_clr   (cnt_clr),
        .loss_cnt  (loss_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference inverse: each code described by where every output bit comes from.
    function automatic logic [W:0] ref_inv(input logic [3:0] c, input logic [W-1:0] d);
        logic [W-1:0] r;
        logic         l;
        r = '0;
        l = 1'b1;
        for (int i = 0; i < W; i++) begin
            case (c)
                4'd0:  begin r[i] = !d[i]; l = 1'b0; end
                4'd3, 4'd7, 4'd8, 4'd11: begin r[i] = d[i]; l = 1'b0; end
                4'd5:  begin r[i] = d[(i + W - 16) % W]; l = 1'b0; end
                4'd14: begin r[i] = (i == 0) ? d[W-1] : (i == W-1) ? d[0] : d[i]; l = 1'b0; end
                4'd1:  r[i] = (i + 1 < W) ? d[i+1] : 1'b0;
                4'd12: r[i] = (i + 2 < W) ? d[i+2] : 1'b0;
                4'd15: r[i] = (i + 5 < W) ? d[i+5] : 1'b0;
                4'd2:  r[i] = (i >= 1) ? d[i-1] : 1'b0;
                4'd13: r[i] = (i >= 2) ? d[i-2] : 1'b0;
                4'd6:  r[i] = (i >= 6) ? d[i-6] : 1'b0;
                4'd4:  r[i] = (i == 4) ? d[0] : 1'b0;
                default: r[i] = 1'b0;
            endcase
        end
        return {l, r};
    endfunction

    // Forward permutations for the exact codes used in round-trip tests.
    function automatic logic [W-1:0] fwd(input logic [3:0] c, input logic [W-1:0] x);
        logic [W-1:0] r;
        r = x;
        for (int i = 0; i < W; i++) begin
            if (c == 4'd5) r[i] = x[(i + 16) % W];
            else if (c == 4'd14) r[i] = (i == 0) ? x[W-1] : (i == W-1) ? x[0] : x[i];
        end
        return r;
    endfunction

    // Model state: FIFO contents, last presented word, counter.
    logic [W:0] q[$];
    logic [W:0] last_head;
    int         mcnt;

    always @(negedge clk) begin
        logic [W:0] exp_head;
        logic       mpush, mpop;
        if (!rst_n) begin
            q.delete();
            last_head = '0;
            mcnt      = 0;
        end else begin
            chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
            chk("in_ready", 64'(in_ready), 64'(q.size() != 2));
            if (q.size() != 0) last_head = q[0];
            exp_head = last_head;
            chk("out_data", 64'(out_data), 64'(exp_head[W-1:0]));
            chk("out_lossy", 64'(out_lossy), 64'(exp_head[W]));
            chk("loss_cnt", 64'(loss_cnt), 64'(mcnt));
            mpop  = (q.size() != 0) && out_ready;
            mpush = in_valid && (q.size() != 2);
`ifdef DEPERM_LOSSCNT_EN
            if (cnt_clr) mcnt = 0;
            else if (mpop && q[0][W] && mcnt < (1 << CW) - 1) mcnt = mcnt + 1;
`endif
            if (mpop) void'(q.pop_front());
            if (mpush) q.push_back(ref_inv(in_cntrl, in_data));
        end
    end

    task automatic idle_drain();
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Push one word into an empty buffer and check it one cycle later.
    task automatic send_one(input logic [3:0] c, input logic [W-1:0] d,
                            input logic [W-1:0] exp_d, input logic exp_l, input string name);
        @(posedge clk);
        #1;
        in_valid  = 1'b1;
        in_data   = d;
        in_cntrl  = c;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk({name, "_valid"}, 64'(out_valid), 64'd1);
        chk({name, "_data"}, 64'(out_data), 64'(exp_d));
        chk({name, "_lossy"}, 64'(out_lossy), 64'(exp_l));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] rnd;
        logic [W-1:0] x, w0, w1, w2;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_cntrl  = '0;
        out_ready = 1'b0;
        cnt_clr   = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_loss_cnt", 64'(loss_cnt), 64'd0);
        rst_n = 1'b1;

        // Hand-computed literal expectations.
        send_one(4'd0, 37'h0_0000_0001, 37'h1F_FFFF_FFFE, 1'b0, "inv0");
        send_one(4'd2, 37'h10_0000_0001, 37'h00_0000_0002, 1'b1, "shl1");
        send_one(4'd4, 37'h1F_FFFF_FFFF, 37'h00_0000_0010, 1'b1, "bit4");
        send_one(4'd14, 37'h0_0000_0001, 37'h10_0000_0000, 1'b0, "swap");
        send_one(4'd15, 37'h1F_FFFF_FFFF, 37'h00_FFFF_FFFF, 1'b1, "shr5");
        send_one(4'd5, 37'h0_0000_0001, 37'h0_0001_0000, 1'b0, "rot");
        send_one(4'd9, 37'h1F_FFFF_FFFF, 37'h0, 1'b1, "zero9");

        // Round trips through the forward permutation.
        for (int k = 0; k < 6; k++) begin
            rnd = {$urandom, $urandom};
            x   = rnd[W-1:0];
            send_one(4'd3, fwd(4'd3, x), x, 1'b0, "rt3");
            send_one(4'd5, fwd(4'd5, x), x, 1'b0, "rt5");
            send_one(4'd14, fwd(4'd14, x), x, 1'b0, "rt14");
        end

        // Back-pressure: two words fill the buffer, third one stalls.
        idle_drain();
        w0 = 37'h01_2345_6789;
        w1 = 37'h1A_BCDE_F012;
        w2 = 37'h05_5555_AAAA;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_cntrl  = 4'd3;
        in_data   = w0;
        @(posedge clk);
        #1;
        in_data = w1;
        @(posedge clk);
        #1;
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        in_data = w2;
        @(posedge clk);
        #1;
        chk("stall_head", 64'(out_data), 64'(w0));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("stall_next", 64'(out_data), 64'(w1));
        chk("stall_ready_back", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("stall_last", 64'(out_data), 64'(w2));
        idle_drain();

`ifdef DEPERM_LOSSCNT_EN
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        send_one(4'd1, 37'h3, 37'h1, 1'b1, "cnt_l0");
        send_one(4'd1, 37'h3, 37'h1, 1'b1, "cnt_l1");
        send_one(4'd1, 37'h3, 37'h1, 1'b1, "cnt_l2");
        send_one(4'd3, 37'h3, 37'h3, 1'b0, "cnt_e0");
        send_one(4'd3, 37'h3, 37'h3, 1'b0, "cnt_e1");
        @(posedge clk);
        #1;
        chk("cnt_three", 64'(loss_cnt), 64'd3);
        send_one(4'd12, 37'h4, 37'h1, 1'b1, "cnt_clrpop");
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        chk("cnt_cleared", 64'(loss_cnt), 64'd0);
`endif

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            @(posedge clk);
            #1;
            rnd       = {$urandom, $urandom};
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = rnd[W-1:0];
            in_cntrl  = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 2) != 0);
            cnt_clr   = ($urandom_range(0, 60) == 0);
        end
        cnt_clr = 1'b0;

        // Reset with the buffer full: everything is dropped at once.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_cntrl  = 4'd0;
        repeat (3) @(posedge clk);
        #2;
        chk("full_before_rst", 64'(in_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
        chk("rst_mid_in_ready", 64'(in_ready), 64'd1);
        chk("rst_mid_out_data", 64'(out_data), 64'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("after_rst_empty", 64'(out_valid), 64'd0);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
